// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// State encodings, opcode map, instruction classes and PC select codes.
package pc_seq_pkg;

    typedef enum logic [3:0] {
        ST_RST0,
        ST_RST1,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_PCSEL,
        ST_PCUPD,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_ILL,
        CLS_LD,
        CLS_ST,
        CLS_JMP,
        CLS_CJMP,
        CLS_HALT
    } class_e;

    localparam logic [3:0] OP_ALU0  = 4'h0;
    localparam logic [3:0] OP_ALU1  = 4'h1;
    localparam logic [3:0] OP_ALU2  = 4'h2;
    localparam logic [3:0] OP_ALU3  = 4'h3;
    localparam logic [3:0] OP_BR    = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;
    localparam logic [3:0] OP_JR    = 4'h6;
    localparam logic [3:0] OP_JM    = 4'h7;
    localparam logic [3:0] OP_JMR   = 4'h8;
    localparam logic [3:0] OP_JCMP  = 4'h9;
    localparam logic [3:0] OP_JCMPL = 4'hA;
    localparam logic [3:0] OP_LD    = 4'hB;
    localparam logic [3:0] OP_ST    = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] PCSRC_SEQ   = 3'b000;
    localparam logic [2:0] PCSRC_BR    = 3'b001;
    localparam logic [2:0] PCSRC_J     = 3'b010;
    localparam logic [2:0] PCSRC_JR    = 3'b011;
    localparam logic [2:0] PCSRC_JM    = 3'b100;
    localparam logic [2:0] PCSRC_JMR   = 3'b101;
    localparam logic [2:0] PCSRC_JCMP  = 3'b110;
    localparam logic [2:0] PCSRC_JCMPL = 3'b111;

endpackage

// File: rtl/pc_seq_decode.sv
// Opcode to instruction-class and PC-select decoder.
// Purely combinational; compare qualification is left to the FSM.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output class_e     cls,
    output logic [2:0] pcsrc
);

    // Map each opcode onto its class and the select it would use if taken
    always_comb begin
        cls   = CLS_ILL;
        pcsrc = PCSRC_SEQ;
        case (opcode)
            OP_ALU0, OP_ALU1,
            OP_ALU2, OP_ALU3: cls = CLS_ALU;
            OP_BR:    begin cls = CLS_JMP;  pcsrc = PCSRC_BR;    end
            OP_J:     begin cls = CLS_JMP;  pcsrc = PCSRC_J;     end
            OP_JR:    begin cls = CLS_JMP;  pcsrc = PCSRC_JR;    end
            OP_JM:    begin cls = CLS_JMP;  pcsrc = PCSRC_JM;    end
            OP_JMR:   begin cls = CLS_JMP;  pcsrc = PCSRC_JMR;   end
            OP_JCMP:  begin cls = CLS_CJMP; pcsrc = PCSRC_JCMP;  end
            OP_JCMPL: begin cls = CLS_CJMP; pcsrc = PCSRC_JCMPL; end
            OP_LD:    cls = CLS_LD;
            OP_ST:    cls = CLS_ST;
            OP_HALT:  cls = CLS_HALT;
            default:  cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the PC path and memory handshake.
// Optional PC_SEQ_PERF_EN adds a 16-bit retired-instruction counter.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic       clock,
    input  logic       resetN,
    input  logic [3:0] opcode,
    input  logic       comp,
    input  logic       memReady,
    output logic       instRead,
    output logic       dataRead,
    output logic       dataWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [3:0] pcSrc,
    output logic       jcmp,
    output logic       pcWrite,
    output logic       pcReset,
    output logic       halted,
    output logic       illegal
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [15:0] instRetired
`endif
);

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    logic [2:0] pcsrc_q, pcsrc_d;
    logic       jcmp_q, jcmp_d;

    class_e     dec_cls;
    logic [2:0] dec_pcsrc;

    pc_seq_decode u_decode (
        .opcode (opcode),
        .cls    (dec_cls),
        .pcsrc  (dec_pcsrc)
    );

    assign pcSrc = {1'b0, pcsrc_q};
    assign jcmp  = jcmp_q;

    // State, latched class and PC select; reset wins from any state
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= ST_RST0;
            cls_q   <= CLS_ALU;
            pcsrc_q <= PCSRC_SEQ;
            jcmp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            pcsrc_q <= pcsrc_d;
            jcmp_q  <= jcmp_d;
        end
    end

    // Next state, select capture at DECODE exit, and strobes
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        pcsrc_d   = pcsrc_q;
        jcmp_d    = jcmp_q;
        instRead  = 1'b0;
        dataRead  = 1'b0;
        dataWrite = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        pcWrite   = 1'b0;
        pcReset   = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        unique case (state_q)
            ST_RST0: begin
                pcReset = 1'b1;
                pcsrc_d = PCSRC_SEQ;
                jcmp_d  = 1'b0;
                state_d = ST_RST1;
            end
            ST_RST1: begin
                pcWrite = 1'b1;
                pcsrc_d = PCSRC_SEQ;
                jcmp_d  = 1'b0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d   = dec_cls;
                pcsrc_d = dec_pcsrc;
                jcmp_d  = 1'b0;
                if (dec_cls == CLS_CJMP) begin
                    if (comp) jcmp_d = 1'b1;
                    else      pcsrc_d = PCSRC_SEQ;
                end
                unique case (dec_cls)
                    CLS_ALU, CLS_ILL: state_d = ST_EXEC;
                    CLS_LD, CLS_ST:   state_d = ST_MEM;
                    CLS_JMP, CLS_CJMP: state_d = ST_PCSEL;
                    CLS_HALT:         state_d = ST_HALT;
                    default:          state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                regWrite = (cls_q == CLS_ALU);
                illegal  = (cls_q == CLS_ILL);
                state_d  = ST_PCUPD;
            end
            ST_MEM: begin
                dataRead  = (cls_q == CLS_LD);
                dataWrite = (cls_q == CLS_ST);
                if (memReady) begin
                    regWrite = (cls_q == CLS_LD);
                    state_d  = ST_PCUPD;
                end
            end
            ST_PCSEL: begin
                state_d = ST_PCUPD;
            end
            ST_PCUPD: begin
                pcWrite = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                pcsrc_d = PCSRC_SEQ;
                jcmp_d  = 1'b0;
            end
            default: begin
                state_d = ST_RST0;
            end
        endcase
    end

`ifdef PC_SEQ_PERF_EN
    logic [15:0] retired_q, retired_d;

    assign instRetired = retired_q;

    // Count one instruction per PC update; cleared while in reset
    always_comb begin
        retired_d = retired_q;
        if (state_q == ST_RST0)
            retired_d = 16'd0;
        else if (state_q == ST_PCUPD)
            retired_d = retired_q + 16'd1;
    end

    // Retired-instruction counter register
    always_ff @(posedge clock) begin
        if (!resetN) retired_q <= 16'd0;
        else         retired_q <= retired_d;
    end
`endif

endmodule
